// File: rtl/rv32i_dec_pkg.sv
// Shared types and constants for the RV32I decode stage.
//   fmt_e / op_e : instruction format and operation codes
//   OPC_*        : major opcode values (instr[6:0])
//   dec_t        : everything the decoder produces for one instruction
// With DEC_RV32M_EN defined, op_e also carries the eight RV32M operations.
package rv32i_dec_pkg;

    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_ILL = 3'd6
    } fmt_e;

    typedef enum logic [5:0] {
        OP_ADD     = 6'd0,  OP_SUB   = 6'd1,  OP_SLL  = 6'd2,  OP_SLT   = 6'd3,
        OP_SLTU    = 6'd4,  OP_XOR   = 6'd5,  OP_SRL  = 6'd6,  OP_SRA   = 6'd7,
        OP_OR      = 6'd8,  OP_AND   = 6'd9,
        OP_ADDI    = 6'd10, OP_SLTI  = 6'd11, OP_SLTIU = 6'd12, OP_XORI = 6'd13,
        OP_ORI     = 6'd14, OP_ANDI  = 6'd15, OP_SLLI = 6'd16, OP_SRLI  = 6'd17,
        OP_SRAI    = 6'd18,
        OP_LB      = 6'd19, OP_LH    = 6'd20, OP_LW   = 6'd21, OP_LBU   = 6'd22,
        OP_LHU     = 6'd23,
        OP_SB      = 6'd24, OP_SH    = 6'd25, OP_SW   = 6'd26,
        OP_BEQ     = 6'd27, OP_BNE   = 6'd28, OP_BLT  = 6'd29, OP_BGE   = 6'd30,
        OP_BLTU    = 6'd31, OP_BGEU  = 6'd32,
        OP_LUI     = 6'd33, OP_AUIPC = 6'd34, OP_JAL  = 6'd35, OP_JALR  = 6'd36,
        OP_FENCE   = 6'd37, OP_ECALL = 6'd38, OP_EBREAK = 6'd39,
        OP_ILLEGAL = 6'd40
`ifdef DEC_RV32M_EN
        ,
        OP_MUL     = 6'd41, OP_MULH  = 6'd42, OP_MULHSU = 6'd43, OP_MULHU = 6'd44,
        OP_DIV     = 6'd45, OP_DIVU  = 6'd46, OP_REM  = 6'd47, OP_REMU  = 6'd48
`endif
    } op_e;

    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        fmt_e        fmt;
        op_e         op;
        logic        op2_sel;
        logic        rs1_en;
        logic        rs2_en;
        logic        rd_we;
        logic        illegal;
    } dec_t;

endpackage

// File: rtl/rv32i_dec_comb.sv
// Combinational RV32I instruction decoder.
//   i_instr : raw 32-bit instruction word
//   o_dec   : decoded fields, immediate, format, operation and enables
// Register fields are always the raw instr slices; enables say which are live.
// Optional RV32M decode is compiled in with DEC_RV32M_EN.
module rv32i_dec_comb
    import rv32i_dec_pkg::*;
(
    input  logic [31:0] i_instr,
    output dec_t        o_dec
);

    logic [6:0] w_opc;
    logic [2:0] w_f3;
    logic [6:0] w_f7;
    logic       w_legal;
    fmt_e       w_fmt;
    op_e        w_op;

    assign w_opc = i_instr[6:0];
    assign w_f3  = i_instr[14:12];
    assign w_f7  = i_instr[31:25];

    // Format and operation selection; any unrecognised combination clears w_legal.
    always_comb begin
        w_legal = 1'b1;
        w_fmt   = FMT_ILL;
        w_op    = OP_ILLEGAL;
        case (w_opc)
            OPC_OP: begin
                w_fmt = FMT_R;
                case (w_f7)
                    7'b0000000: begin
                        case (w_f3)
                            3'b000:  w_op = OP_ADD;
                            3'b001:  w_op = OP_SLL;
                            3'b010:  w_op = OP_SLT;
                            3'b011:  w_op = OP_SLTU;
                            3'b100:  w_op = OP_XOR;
                            3'b101:  w_op = OP_SRL;
                            3'b110:  w_op = OP_OR;
                            default: w_op = OP_AND;
                        endcase
                    end
                    7'b0100000: begin
                        if (w_f3 == 3'b000)      w_op = OP_SUB;
                        else if (w_f3 == 3'b101) w_op = OP_SRA;
                        else                     w_legal = 1'b0;
                    end
`ifdef DEC_RV32M_EN
                    7'b0000001: begin
                        case (w_f3)
                            3'b000:  w_op = OP_MUL;
                            3'b001:  w_op = OP_MULH;
                            3'b010:  w_op = OP_MULHSU;
                            3'b011:  w_op = OP_MULHU;
                            3'b100:  w_op = OP_DIV;
                            3'b101:  w_op = OP_DIVU;
                            3'b110:  w_op = OP_REM;
                            default: w_op = OP_REMU;
                        endcase
                    end
`endif
                    default: w_legal = 1'b0;
                endcase
            end
            OPC_OP_IMM: begin
                w_fmt = FMT_I;
                case (w_f3)
                    3'b000: w_op = OP_ADDI;
                    3'b010: w_op = OP_SLTI;
                    3'b011: w_op = OP_SLTIU;
                    3'b100: w_op = OP_XORI;
                    3'b110: w_op = OP_ORI;
                    3'b111: w_op = OP_ANDI;
                    3'b001: begin
                        if (w_f7 == 7'b0000000) w_op = OP_SLLI;
                        else                    w_legal = 1'b0;
                    end
                    default: begin
                        if (w_f7 == 7'b0000000)      w_op = OP_SRLI;
                        else if (w_f7 == 7'b0100000) w_op = OP_SRAI;
                        else                         w_legal = 1'b0;
                    end
                endcase
            end
            OPC_LOAD: begin
                w_fmt = FMT_I;
                case (w_f3)
                    3'b000:  w_op = OP_LB;
                    3'b001:  w_op = OP_LH;
                    3'b010:  w_op = OP_LW;
                    3'b100:  w_op = OP_LBU;
                    3'b101:  w_op = OP_LHU;
                    default: w_legal = 1'b0;
                endcase
            end
            OPC_STORE: begin
                w_fmt = FMT_S;
                case (w_f3)
                    3'b000:  w_op = OP_SB;
                    3'b001:  w_op = OP_SH;
                    3'b010:  w_op = OP_SW;
                    default: w_legal = 1'b0;
                endcase
            end
            OPC_BRANCH: begin
                w_fmt = FMT_B;
                case (w_f3)
                    3'b000:  w_op = OP_BEQ;
                    3'b001:  w_op = OP_BNE;
                    3'b100:  w_op = OP_BLT;
                    3'b101:  w_op = OP_BGE;
                    3'b110:  w_op = OP_BLTU;
                    3'b111:  w_op = OP_BGEU;
                    default: w_legal = 1'b0;
                endcase
            end
            OPC_LUI:   begin w_fmt = FMT_U; w_op = OP_LUI;   end
            OPC_AUIPC: begin w_fmt = FMT_U; w_op = OP_AUIPC; end
            OPC_JAL:   begin w_fmt = FMT_J; w_op = OP_JAL;   end
            OPC_JALR: begin
                w_fmt = FMT_I;
                if (w_f3 == 3'b000) w_op = OP_JALR;
                else                w_legal = 1'b0;
            end
            OPC_MISC_MEM: begin
                w_fmt = FMT_I;
                if (w_f3 == 3'b000) w_op = OP_FENCE;
                else                w_legal = 1'b0;
            end
            OPC_SYSTEM: begin
                // Only the exact ECALL / EBREAK words are supported (no CSR ops).
                w_fmt = FMT_I;
                if (i_instr[31:7] == 25'h0000000)      w_op = OP_ECALL;
                else if (i_instr[31:7] == 25'h0002000) w_op = OP_EBREAK;
                else                                   w_legal = 1'b0;
            end
            default: w_legal = 1'b0;
        endcase
    end

    // Immediate, enables and the illegal override.
    always_comb begin
        o_dec         = '0;
        o_dec.rs1     = i_instr[19:15];
        o_dec.rs2     = i_instr[24:20];
        o_dec.rd      = i_instr[11:7];
        o_dec.fmt     = FMT_ILL;
        o_dec.op      = OP_ILLEGAL;
        o_dec.illegal = 1'b1;
        if (w_legal) begin
            o_dec.fmt     = w_fmt;
            o_dec.op      = w_op;
            o_dec.illegal = 1'b0;
            case (w_fmt)
                FMT_I:   o_dec.imm = {{20{i_instr[31]}}, i_instr[31:20]};
                FMT_S:   o_dec.imm = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
                FMT_B:   o_dec.imm = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                                      i_instr[30:25], i_instr[11:8], 1'b0};
                FMT_U:   o_dec.imm = {i_instr[31:12], 12'b0};
                FMT_J:   o_dec.imm = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                                      i_instr[20], i_instr[30:21], 1'b0};
                default: o_dec.imm = 32'd0;
            endcase
            o_dec.rs1_en  = (w_fmt != FMT_U) && (w_fmt != FMT_J);
            o_dec.rs2_en  = (w_fmt == FMT_R) || (w_fmt == FMT_S) || (w_fmt == FMT_B);
            o_dec.op2_sel = (w_fmt == FMT_I) || (w_fmt == FMT_S) ||
                            (w_fmt == FMT_U) || (w_fmt == FMT_J);
            o_dec.rd_we   = (i_instr[11:7] != 5'd0) &&
                            (w_fmt != FMT_S) && (w_fmt != FMT_B) &&
                            (w_op != OP_FENCE) && (w_op != OP_ECALL) && (w_op != OP_EBREAK);
        end
    end

endmodule

// File: rtl/rv32i_decode_stage.sv
// Registered RV32I decode stage between fetch and execute.
//   in_valid/in_ready/in_instr/in_pc  : fetch-side handshake
//   out_valid/out_ready/out_*          : execute-side handshake and decoded fields
//   flush                              : drop everything held and incoming
//   ill_cnt                            : saturating count of accepted illegal words
// Two-entry skid buffer (main + skid) so in_ready comes only from the state
// register. Optional RV32M decode: define DEC_RV32M_EN.
module rv32i_decode_stage
    import rv32i_dec_pkg::*;
#(
    parameter int PC_W      = 32,
    parameter int ILL_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_instr,
    input  logic [PC_W-1:0]      in_pc,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PC_W-1:0]      out_pc,
    output logic [4:0]           out_rs1,
    output logic [4:0]           out_rs2,
    output logic [4:0]           out_rd,
    output logic [31:0]          out_imm,
    output logic [2:0]           out_fmt,
    output logic [5:0]           out_op,
    output logic                 out_op2_sel,
    output logic                 out_rs1_en,
    output logic                 out_rs2_en,
    output logic                 out_rd_we,
    output logic                 out_illegal,
    output logic [ILL_CNT_W-1:0] ill_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    state_e                r_state;
    state_e                w_state_next;
    dec_t                  w_dec;
    dec_t                  r_main_dec;
    dec_t                  r_skid_dec;
    logic [PC_W-1:0]       r_main_pc;
    logic [PC_W-1:0]       r_skid_pc;
    logic [ILL_CNT_W-1:0]  r_ill_cnt;
    logic                  w_in_xfer;
    logic                  w_out_xfer;
    logic                  w_load_main_in;
    logic                  w_load_main_skid;
    logic                  w_load_skid_in;
    logic                  w_count_ill;

    rv32i_dec_comb u_dec (
        .i_instr (in_instr),
        .o_dec   (w_dec)
    );

    assign in_ready   = (r_state != ST_FULL);
    assign out_valid  = (r_state != ST_EMPTY);
    assign w_in_xfer  = in_valid && in_ready;
    assign w_out_xfer = out_valid && out_ready;

    // Flush wins over every handshake: nothing is loaded and the stage empties.
    always_comb begin
        w_state_next     = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid_in   = 1'b0;
        if (flush) begin
            w_state_next = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_xfer) begin
                        w_load_main_in = 1'b1;
                        w_state_next   = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_in_xfer && !w_out_xfer) begin
                        w_load_skid_in = 1'b1;
                        w_state_next   = ST_FULL;
                    end else if (!w_in_xfer && w_out_xfer) begin
                        w_state_next   = ST_EMPTY;
                    end else if (w_in_xfer && w_out_xfer) begin
                        w_load_main_in = 1'b1;
                    end
                end
                ST_FULL: begin
                    if (w_out_xfer) begin
                        w_load_main_skid = 1'b1;
                        w_state_next     = ST_ONE;
                    end
                end
                default: w_state_next = ST_EMPTY;
            endcase
        end
    end

    assign w_count_ill = w_in_xfer && !flush && w_dec.illegal && (r_ill_cnt != '1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_EMPTY;
            r_main_dec <= '0;
            r_skid_dec <= '0;
            r_main_pc  <= '0;
            r_skid_pc  <= '0;
            r_ill_cnt  <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_load_main_in) begin
                r_main_dec <= w_dec;
                r_main_pc  <= in_pc;
            end else if (w_load_main_skid) begin
                r_main_dec <= r_skid_dec;
                r_main_pc  <= r_skid_pc;
            end
            if (w_load_skid_in) begin
                r_skid_dec <= w_dec;
                r_skid_pc  <= in_pc;
            end
            if (w_count_ill) begin
                r_ill_cnt <= r_ill_cnt + 1'b1;
            end
        end
    end

    assign out_pc      = r_main_pc;
    assign out_rs1     = r_main_dec.rs1;
    assign out_rs2     = r_main_dec.rs2;
    assign out_rd      = r_main_dec.rd;
    assign out_imm     = r_main_dec.imm;
    assign out_fmt     = r_main_dec.fmt;
    assign out_op      = r_main_dec.op;
    assign out_op2_sel = r_main_dec.op2_sel;
    assign out_rs1_en  = r_main_dec.rs1_en;
    assign out_rs2_en  = r_main_dec.rs2_en;
    assign out_rd_we   = r_main_dec.rd_we;
    assign out_illegal = r_main_dec.illegal;
    assign ill_cnt     = r_ill_cnt;

endmodule

// File: tb/tb_rv32i_decode_stage.sv
// Bench for rv32i_decode_stage: a queue-based occupancy model plus a
// table-driven reference decoder; a second instance with ILL_CNT_W=2 and
// out_ready held high exercises counter saturation.
module tb_rv32i_decode_stage;
    import rv32i_dec_pkg::*;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, in_valid, flush, out_ready, one_r;
    logic [31:0] in_instr, in_pc;

    logic        in_ready, out_valid, out_op2_sel, out_rs1_en, out_rs2_en, out_rd_we, out_illegal;
    logic [31:0] out_pc, out_imm;
    logic [4:0]  out_rs1, out_rs2, out_rd;
    logic [2:0]  out_fmt;
    logic [5:0]  out_op;
    logic [15:0] ill_cnt;

    logic        in_ready_b, out_valid_b, out_op2_sel_b, out_rs1_en_b, out_rs2_en_b, out_rd_we_b, out_illegal_b;
    logic [31:0] out_pc_b, out_imm_b;
    logic [4:0]  out_rs1_b, out_rs2_b, out_rd_b;
    logic [2:0]  out_fmt_b;
    logic [5:0]  out_op_b;
    logic [1:0]  ill_cnt_b;

    rv32i_decode_stage #(.PC_W(32), .ILL_CNT_W(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_pc(out_pc), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_rd(out_rd), .out_imm(out_imm), .out_fmt(out_fmt), .out_op(out_op),
        .out_op2_sel(out_op2_sel), .out_rs1_en(out_rs1_en), .out_rs2_en(out_rs2_en),
        .out_rd_we(out_rd_we), .out_illegal(out_illegal), .ill_cnt(ill_cnt)
    );

    rv32i_decode_stage #(.PC_W(32), .ILL_CNT_W(2)) dut_small (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid_b),
        .out_ready(one_r), .out_pc(out_pc_b), .out_rs1(out_rs1_b), .out_rs2(out_rs2_b),
        .out_rd(out_rd_b), .out_imm(out_imm_b), .out_fmt(out_fmt_b), .out_op(out_op_b),
        .out_op2_sel(out_op2_sel_b), .out_rs1_en(out_rs1_en_b), .out_rs2_en(out_rs2_en_b),
        .out_rd_we(out_rd_we_b), .out_illegal(out_illegal_b), .ill_cnt(ill_cnt_b)
    );

    int n_chk = 0;
    int n_err = 0;

    // ---------------- reference model ----------------
    localparam op_e R_TAB [8] = '{OP_ADD, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_OR, OP_AND};
    localparam op_e I_TAB [8] = '{OP_ADDI, OP_SLLI, OP_SLTI, OP_SLTIU, OP_XORI, OP_SRLI, OP_ORI, OP_ANDI};
    localparam op_e L_TAB [8] = '{OP_LB, OP_LH, OP_LW, OP_ILLEGAL, OP_LBU, OP_LHU, OP_ILLEGAL, OP_ILLEGAL};
    localparam op_e S_TAB [8] = '{OP_SB, OP_SH, OP_SW, OP_ILLEGAL, OP_ILLEGAL, OP_ILLEGAL, OP_ILLEGAL, OP_ILLEGAL};
    localparam op_e B_TAB [8] = '{OP_BEQ, OP_BNE, OP_ILLEGAL, OP_ILLEGAL, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU};
`ifdef DEC_RV32M_EN
    localparam op_e M_TAB [8] = '{OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU};
`endif
    localparam logic [6:0] OPCS [11] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37,
                                         7'h17, 7'h6F, 7'h67, 7'h0F, 7'h73};

    function automatic dec_t ref_dec(input logic [31:0] w);
        dec_t       d;
        fmt_e       f;
        op_e        o;
        logic [2:0] f3;
        logic [6:0] f7;
        f3 = w[14:12];
        f7 = w[31:25];
        f  = FMT_I;
        o  = OP_ILLEGAL;
        case (w[6:0])
            7'h33: begin
                f = FMT_R;
                if (f7 == 7'h00) o = R_TAB[f3];
                else if (f7 == 7'h20 && f3 == 3'd0) o = OP_SUB;
                else if (f7 == 7'h20 && f3 == 3'd5) o = OP_SRA;
`ifdef DEC_RV32M_EN
                else if (f7 == 7'h01) o = M_TAB[f3];
`endif
            end
            7'h13: begin
                o = I_TAB[f3];
                if (f3 == 3'd1 && f7 != 7'h00) o = OP_ILLEGAL;
                if (f3 == 3'd5 && f7 == 7'h20) o = OP_SRAI;
                else if (f3 == 3'd5 && f7 != 7'h00) o = OP_ILLEGAL;
            end
            7'h03: o = L_TAB[f3];
            7'h23: begin f = FMT_S; o = S_TAB[f3]; end
            7'h63: begin f = FMT_B; o = B_TAB[f3]; end
            7'h37: begin f = FMT_U; o = OP_LUI; end
            7'h17: begin f = FMT_U; o = OP_AUIPC; end
            7'h6F: begin f = FMT_J; o = OP_JAL; end
            7'h67: if (f3 == 3'd0) o = OP_JALR;
            7'h0F: if (f3 == 3'd0) o = OP_FENCE;
            7'h73: begin
                if (w == 32'h0000_0073) o = OP_ECALL;
                else if (w == 32'h0010_0073) o = OP_EBREAK;
            end
            default: o = OP_ILLEGAL;
        endcase
        d     = '0;
        d.rs1 = w[19:15];
        d.rs2 = w[24:20];
        d.rd  = w[11:7];
        if (o == OP_ILLEGAL) begin
            d.fmt = FMT_ILL;
            d.op = OP_ILLEGAL;
            d.illegal = 1'b1;
        end else begin
            d.fmt = f;
            d.op  = o;
            case (f)
                FMT_I: d.imm = 32'($signed(w[31:20]));
                FMT_S: d.imm = 32'($signed({w[31:25], w[11:7]}));
                FMT_B: d.imm = 32'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
                FMT_U: d.imm = w & 32'hFFFF_F000;
                FMT_J: d.imm = 32'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
                default: d.imm = 32'd0;
            endcase
            d.rs1_en  = !(f inside {FMT_U, FMT_J});
            d.rs2_en  = f inside {FMT_R, FMT_S, FMT_B};
            d.op2_sel = f inside {FMT_I, FMT_S, FMT_U, FMT_J};
            d.rd_we   = (w[11:7] != 0) && !(f inside {FMT_S, FMT_B}) &&
                        !(o inside {OP_FENCE, OP_ECALL, OP_EBREAK});
        end
        return d;
    endfunction

    function automatic dec_t dut_dec();
        dec_t d;
        d.rs1 = out_rs1; d.rs2 = out_rs2; d.rd = out_rd; d.imm = out_imm;
        d.fmt = fmt_e'(out_fmt); d.op = op_e'(out_op);
        d.op2_sel = out_op2_sel; d.rs1_en = out_rs1_en; d.rs2_en = out_rs2_en;
        d.rd_we = out_rd_we; d.illegal = out_illegal;
        return d;
    endfunction

    typedef struct { logic [31:0] pc; logic [31:0] instr; } item_t;
    item_t q[$];
    int    m_cnt, m_cnt2;

    // Drive one cycle and advance the model: the stage holds at most two
    // instructions in order; flush/reset empty it.
    task automatic cycle(input logic v, input logic [31:0] w, input logic [31:0] pc,
                         input logic ordy, input logic fl);
        logic ox, ix, ill;
        in_valid = v; in_instr = w; in_pc = pc; out_ready = ordy; flush = fl;
        ill = ref_dec(w).illegal;
        ox  = (q.size() > 0) && ordy;
        ix  = v && (q.size() < 2);
        @(posedge clk);
        if (reset) begin
            q.delete(); m_cnt = 0; m_cnt2 = 0;
        end else if (fl) begin
            q.delete();
        end else begin
            if (ox) void'(q.pop_front());
            if (ix) begin
                q.push_back('{pc, w});
                if (ill && m_cnt < 65535) m_cnt++;
            end
            if (v && ill && m_cnt2 < 3) m_cnt2++;
        end
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        cycle(1'b1, 32'hFFFF_FFFF, 32'h44, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        reset = 1'b0;
        n_chk++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_chk++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        n_chk++; if (ill_cnt !== 16'd0) begin n_err++; $display("FAIL reset_ill_cnt got=%0d exp=0", ill_cnt); end
        n_chk++; if (out_pc !== 32'd0) begin n_err++; $display("FAIL reset_out_pc got=%h exp=0", out_pc); end
        n_chk++; if (dut_dec() !== dec_t'('0)) begin n_err++; $display("FAIL reset_fields got=%h exp=0", dut_dec()); end
        $display("reset: out_valid=%b in_ready=%b ill_cnt=%0d", out_valid, in_ready, ill_cnt);
    endtask

    task automatic test_directed();
        logic [31:0] words [10] = '{32'hFFF0_8293, 32'hFE20_8CE3, 32'h0020_8033, 32'h0220_8033,
                                    32'h0080_00EF, 32'hFE20_AE23, 32'h4052_5193, 32'h4052_1193,
                                    32'h0000_0073, 32'h1234_51B7};
        // {fmt, op, imm, op2_sel, rs1_en, rs2_en, rd_we, illegal}
        fmt_e  efmt [10] = '{FMT_I, FMT_B, FMT_R, FMT_R, FMT_J, FMT_S, FMT_I, FMT_ILL, FMT_I, FMT_U};
        op_e   eop  [10];
        logic [31:0] eimm [10] = '{32'hFFFF_FFFF, 32'hFFFF_FFF8, 32'h0, 32'h0, 32'h8,
                                   32'hFFFF_FFFC, 32'h405, 32'h0, 32'h0, 32'h1234_5000};
        logic [4:0] een [10] = '{5'b11010, 5'b01100, 5'b01100, 5'b01100, 5'b10010,
                                 5'b11100, 5'b11010, 5'b00001, 5'b11000, 5'b10010};
        dec_t exp;
        eop = '{OP_ADDI, OP_BEQ, OP_ADD, OP_ILLEGAL, OP_JAL, OP_SW, OP_SRAI, OP_ILLEGAL, OP_ECALL, OP_LUI};
`ifdef DEC_RV32M_EN
        efmt[3] = FMT_R; eop[3] = OP_MUL; een[3] = 5'b01100;
`else
        efmt[3] = FMT_ILL; een[3] = 5'b00001;
`endif
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, words[i], 32'h100 + 32'(i * 4), 1'b1, 1'b0);
            exp = '0;
            exp.rs1 = words[i][19:15]; exp.rs2 = words[i][24:20]; exp.rd = words[i][11:7];
            exp.fmt = efmt[i]; exp.op = eop[i]; exp.imm = eimm[i];
            {exp.op2_sel, exp.rs1_en, exp.rs2_en, exp.rd_we, exp.illegal} = een[i];
            n_chk++;
            if (out_valid !== 1'b1 || out_pc !== 32'h100 + 32'(i * 4) || dut_dec() !== exp) begin
                n_err++;
                $display("FAIL directed_%0d instr=%h got v=%b pc=%h dec=%h exp pc=%h dec=%h",
                         i, words[i], out_valid, out_pc, dut_dec(), 32'h100 + 32'(i * 4), exp);
            end
            $display("directed: instr=%h pc=%h fmt=%0d op=%0d imm=%h", words[i], out_pc, out_fmt, out_op, out_imm);
        end
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        n_chk++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL directed_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] wa = 32'h0010_0093, wb = 32'h0020_0113, wc = 32'h0030_0193;
        cycle(1'b1, wa, 32'hA00, 1'b0, 1'b0);
        n_chk++; if (in_ready !== 1'b1 || out_pc !== 32'hA00) begin n_err++; $display("FAIL b2b_first got rdy=%b pc=%h exp rdy=1 pc=a00", in_ready, out_pc); end
        cycle(1'b1, wb, 32'hB00, 1'b0, 1'b0);
        n_chk++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_full_ready got=%b exp=0", in_ready); end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, wc, 32'hC00, 1'b0, 1'b0);
            n_chk++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_pc !== 32'hA00 || dut_dec() !== ref_dec(wa)) begin
                n_err++;
                $display("FAIL b2b_stall_%0d got rdy=%b v=%b pc=%h dec=%h exp rdy=0 v=1 pc=a00 dec=%h",
                         i, in_ready, out_valid, out_pc, dut_dec(), ref_dec(wa));
            end
            $display("b2b: stall cycle %0d out_pc=%h in_ready=%b", i, out_pc, in_ready);
        end
        cycle(1'b1, wc, 32'hC00, 1'b1, 1'b0);
        n_chk++; if (out_pc !== 32'hB00 || in_ready !== 1'b1 || dut_dec() !== ref_dec(wb)) begin n_err++; $display("FAIL b2b_drain_b got pc=%h rdy=%b exp pc=b00 rdy=1", out_pc, in_ready); end
        cycle(1'b1, wc, 32'hC00, 1'b1, 1'b0);
        n_chk++; if (out_pc !== 32'hC00 || out_valid !== 1'b1 || dut_dec() !== ref_dec(wc)) begin n_err++; $display("FAIL b2b_drain_c got pc=%h v=%b exp pc=c00 v=1", out_pc, out_valid); end
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        n_chk++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_empty got=%b exp=0", out_valid); end
        $display("b2b: drained A,B,C in order");
    endtask

    task automatic test_flush();
        cycle(1'b1, 32'h0010_0093, 32'hD00, 1'b0, 1'b0);
        cycle(1'b1, 32'h0020_0113, 32'hD04, 1'b0, 1'b0);
        cycle(1'b1, 32'hFFFF_FFFF, 32'hD08, 1'b0, 1'b1);
        n_chk++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL flush_now got v=%b rdy=%b exp v=0 rdy=1", out_valid, in_ready); end
        n_chk++; if (ill_cnt !== 16'(m_cnt)) begin n_err++; $display("FAIL flush_nocount got=%0d exp=%0d", ill_cnt, m_cnt); end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
            n_chk++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_after_%0d got v=%b pc=%h exp v=0", i, out_valid, out_pc); end
        end
        $display("flush: out_valid=%b in_ready=%b", out_valid, in_ready);
    endtask

    task automatic test_illegal();
        reset = 1'b1; cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0); reset = 1'b0;
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'hFFFF_FFFF, 32'hE00, 1'b1, 1'b0);
        n_chk++; if (ill_cnt !== 16'd3) begin n_err++; $display("FAIL ill_cnt3 got=%0d exp=3", ill_cnt); end
        n_chk++; if (out_illegal !== 1'b1 || out_fmt !== 3'(FMT_ILL) || out_op !== 6'(OP_ILLEGAL) || out_imm !== 32'd0)
            begin n_err++; $display("FAIL ill_fields got ill=%b fmt=%0d op=%0d imm=%h exp 1/6/40/0", out_illegal, out_fmt, out_op, out_imm); end
        for (int i = 0; i < 2; i++) cycle(1'b1, 32'hFFFF_FFFF, 32'hE00, 1'b1, 1'b0);
        n_chk++; if (ill_cnt_b !== 2'd3) begin n_err++; $display("FAIL ill_sat2 got=%0d exp=3", ill_cnt_b); end
        n_chk++; if (ill_cnt !== 16'd5) begin n_err++; $display("FAIL ill_cnt5 got=%0d exp=5", ill_cnt); end
        reset = 1'b1; cycle(1'b1, 32'hFFFF_FFFF, 32'hE00, 1'b1, 1'b0); reset = 1'b0;
        n_chk++; if (ill_cnt !== 16'd0 || out_valid !== 1'b0 || in_ready !== 1'b1)
            begin n_err++; $display("FAIL ill_midreset got cnt=%0d v=%b rdy=%b exp 0/0/1", ill_cnt, out_valid, in_ready); end
        $display("illegal: ill_cnt=%0d ill_cnt_small=%0d", ill_cnt, ill_cnt_b);
    endtask

    task automatic test_random();
        logic [31:0] w;
        logic        v, r, fl;
        int          errs0 = n_err;
        for (int i = 0; i < 600; i++) begin
            w = $urandom;
            if ($urandom_range(7) != 0) w[6:0] = OPCS[$urandom_range(10)];
            case ($urandom_range(3))
                0: w[31:25] = 7'h00;
                1: w[31:25] = 7'h20;
                2: w[31:25] = 7'h01;
                default: ;
            endcase
            if ($urandom_range(15) == 0) w = ($urandom_range(1) == 0) ? 32'h0000_0073 : 32'h0010_0073;
            v  = ($urandom_range(9) < 7);
            r  = ($urandom_range(9) < 6);
            fl = ($urandom_range(31) == 0);
            cycle(v, w, $urandom, r, fl);
            n_chk++; if (out_valid !== (q.size() > 0)) begin n_err++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", i, out_valid, q.size() > 0); end
            n_chk++; if (in_ready !== (q.size() < 2)) begin n_err++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", i, in_ready, q.size() < 2); end
            n_chk++; if (ill_cnt !== 16'(m_cnt) || ill_cnt_b !== 2'(m_cnt2))
                begin n_err++; $display("FAIL rnd_cnt cyc=%0d got=%0d/%0d exp=%0d/%0d", i, ill_cnt, ill_cnt_b, m_cnt, m_cnt2); end
            if (q.size() > 0) begin
                n_chk++;
                if (out_pc !== q[0].pc || dut_dec() !== ref_dec(q[0].instr)) begin
                    n_err++;
                    $display("FAIL rnd_head cyc=%0d instr=%h got pc=%h dec=%h exp pc=%h dec=%h",
                             i, q[0].instr, out_pc, dut_dec(), q[0].pc, ref_dec(q[0].instr));
                end
            end
        end
        $display("random: 600 cycles, new errors=%0d, ill_cnt=%0d", n_err - errs0, ill_cnt);
    endtask

    initial begin
        reset = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; one_r = 1'b1;
        in_instr = 32'h0; in_pc = 32'h0;
        m_cnt = 0; m_cnt2 = 0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_flush();
        test_illegal();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
